// File: rtl/cdb_pkg.sv
// Shared constants and the result packet type for the common-data-bus arbiter.
// The top and the per-source FIFO both take their widths from here.
package cdb_pkg;

  localparam int NUM_SRC        = 4;
  localparam int TAG_W          = 6;
  localparam int DATA_W         = 32;
  localparam int CDB_FIFO_DEPTH = 2;
  localparam int IDX_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_pkt_t;

  // Round-robin successor of a granted index, wrapping modulo NUM_SRC.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    return (int'(g) == NUM_SRC - 1) ? '0 : g + IDX_W'(1);
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: synchronous push/pop/flush with full/empty and head.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = CDB_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_flush,
  input  logic     i_push,
  input  cdb_pkt_t i_push_pkt,
  input  logic     i_pop,
  output logic     o_full,
  output logic     o_empty,
  output cdb_pkt_t o_head
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_pkt_t          r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after it is written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_pkt;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers each unit's results, grants one non-empty
// source per cycle by round-robin and drives a registered tag/data broadcast.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [IDX_W-1:0]          cdb_src,
  output logic                      busy
);

  // Handshake: a source transfers on a rising edge where src_valid & src_ready;
  // src_ready comes only from registered FIFO occupancy plus reset/flush.
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_req;
  cdb_pkt_t           w_push_pkt [NUM_SRC];
  cdb_pkt_t           w_head     [NUM_SRC];
  logic               w_gnt_valid;
  logic [IDX_W-1:0]   w_gnt_idx;

  logic [IDX_W-1:0]   r_ptr;
  logic               r_valid;
  logic [TAG_W-1:0]   r_tag;
  logic [DATA_W-1:0]  r_data;
  logic [IDX_W-1:0]   r_src;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_ready[i]  = ~w_full[i] & reset & ~flush;
    assign w_push[i]     = src_valid[i] & src_ready[i];
    assign w_push_pkt[i] = {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
    assign w_req[i]      = ~w_empty[i];
    assign w_pop[i]      = w_gnt_valid & (w_gnt_idx == IDX_W'(i)) & ~flush;

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_flush    (flush),
      .i_push     (w_push[i]),
      .i_push_pkt (w_push_pkt[i]),
      .i_pop      (w_pop[i]),
      .o_full     (w_full[i]),
      .o_empty    (w_empty[i]),
      .o_head     (w_head[i])
    );
  end

  // First requester at or after r_ptr, wrapping, wins the bus.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int j;
      j = (int'(r_ptr) + k) % NUM_SRC;
      if (!w_gnt_valid && w_req[j]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_gnt_valid) begin
      r_ptr   <= rr_next(w_gnt_idx);
      r_valid <= 1'b1;
      r_tag   <= w_head[w_gnt_idx].tag;
      r_data  <= w_head[w_gnt_idx].data;
      r_src   <= w_gnt_idx;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign cdb_valid = r_valid;
  assign cdb_tag   = r_tag;
  assign cdb_data  = r_data;
  assign cdb_src   = r_src;
  assign busy      = (|w_req) | r_valid;

endmodule
